// File: rtl/console_sequencer_pkg.sv
// rtl/console_sequencer_pkg.sv - shared console state enum, display selects and PC increment helper.
// Build option CONSOLE_DEP_AUTOINC_EN adds the post-deposit PC increment state.
package console_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOPPING,
      ST_HALTED,
      ST_STEP,
      ST_DEP_REQ
`ifdef CONSOLE_DEP_AUTOINC_EN
      , ST_DEP_INC
`endif
   } console_state_e;

   localparam logic [1:0] DISP_PC = 2'b00;
   localparam logic [1:0] DISP_AC = 2'b01;
   localparam logic [1:0] DISP_MA = 2'b10;
   localparam logic [1:0] DISP_MB = 2'b11;

   // 12-bit wrap gives 7777 -> 0000 for free
   function automatic logic [11:0] pc_next(input logic [11:0] addr);
      return addr + 12'd1;
   endfunction

endpackage

// File: rtl/console_disp_mux.sv
// rtl/console_disp_mux.sv - registered front-panel display selector and link lamp.
module console_disp_mux
   import console_sequencer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  dispsel,
   input  logic [11:0] cpu_pc,
   input  logic [11:0] cpu_ac,
   input  logic [11:0] cpu_ma,
   input  logic [11:0] cpu_mb,
   input  logic        cpu_link,
   output logic [11:0] dispout,
   output logic        linkout
);

   always_ff @(posedge clock) begin
      if (reset) begin
         dispout <= '0;
         linkout <= 1'b0;
      end else begin
         linkout <= cpu_link;
         case (dispsel)
            DISP_PC: dispout <= cpu_pc;
            DISP_AC: dispout <= cpu_ac;
            DISP_MA: dispout <= cpu_ma;
            default: dispout <= cpu_mb;
         endcase
      end
   end

endmodule

// File: rtl/console_sequencer.sv
// rtl/console_sequencer.sv - front-panel console sequencer: run/stop/step/load/deposit control.
// CONSOLE_DEP_AUTOINC_EN: when defined, a deposit is followed by a PC load of address+1.
module console_sequencer
   import console_sequencer_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] swreg,
   input  logic        run,
   input  logic        loadpc,
   input  logic        loadac,
   input  logic        step,
   input  logic        deposit,
   input  logic [1:0]  dispsel,
   output logic [11:0] dispout,
   output logic        linkout,
   input  logic [11:0] cpu_pc,
   input  logic [11:0] cpu_ac,
   input  logic [11:0] cpu_ma,
   input  logic [11:0] cpu_mb,
   input  logic        cpu_link,
   input  logic        cpu_done,
   input  logic        cpu_halt,
   output logic        cpu_go,
   output logic        pc_load,
   output logic        ac_load,
   output logic [11:0] pc_data,
   output logic [11:0] ac_data,
   output logic        mem_wr_req,
   output logic [11:0] mem_addr,
   output logic [11:0] mem_wdata,
   input  logic        mem_wr_ack,
   output logic        busy
);

   console_state_e state;

   logic panel_ok;
   logic fire_pc;
   logic fire_ac;
   logic fire_dep;
   logic fire_step;
   logic dep_inc;

   // Panel pulses only act in IDLE with run low; lower-priority pulses are dropped.
   assign panel_ok  = !reset && (state == ST_IDLE) && !run;
   assign fire_pc   = panel_ok && loadpc;
   assign fire_ac   = panel_ok && !loadpc && loadac;
   assign fire_dep  = panel_ok && !loadpc && !loadac && deposit;
   assign fire_step = panel_ok && !loadpc && !loadac && !deposit && step;

`ifdef CONSOLE_DEP_AUTOINC_EN
   assign dep_inc = !reset && (state == ST_DEP_INC);
`else
   assign dep_inc = 1'b0;
`endif

   assign busy = (state != ST_IDLE);

   always_comb begin
      pc_load = fire_pc || dep_inc;
      pc_data = '0;
      if (fire_pc)
         pc_data = swreg;
      else if (dep_inc)
         pc_data = pc_next(mem_addr);
      ac_load = fire_ac;
      ac_data = fire_ac ? swreg : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         cpu_go     <= 1'b0;
         mem_wr_req <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         cpu_go     <= 1'b0;
         mem_wr_req <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (run) begin
                  state  <= ST_RUN;
                  cpu_go <= 1'b1;
               end else if (fire_dep) begin
                  state      <= ST_DEP_REQ;
                  mem_addr   <= cpu_pc;
                  mem_wdata  <= swreg;
                  mem_wr_req <= 1'b1;
               end else if (fire_step) begin
                  state  <= ST_STEP;
                  cpu_go <= 1'b1;
               end
            end
            ST_RUN: begin
               if (cpu_halt)
                  state <= ST_HALTED;
               else if (!run)
                  state <= ST_STOPPING;
               else
                  cpu_go <= 1'b1;
            end
            ST_STOPPING: begin
               if (cpu_done)
                  state <= ST_IDLE;
               else if (run) begin
                  state  <= ST_RUN;
                  cpu_go <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (!run)
                  state <= ST_IDLE;
            end
            ST_STEP: begin
               if (cpu_done || cpu_halt)
                  state <= ST_IDLE;
            end
            ST_DEP_REQ: begin
               if (mem_wr_ack)
`ifdef CONSOLE_DEP_AUTOINC_EN
                  state <= ST_DEP_INC;
`else
                  state <= ST_IDLE;
`endif
               else
                  mem_wr_req <= 1'b1;
            end
`ifdef CONSOLE_DEP_AUTOINC_EN
            ST_DEP_INC: state <= ST_IDLE;
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

   console_disp_mux u_disp (
      .clock    (clock),
      .reset    (reset),
      .dispsel  (dispsel),
      .cpu_pc   (cpu_pc),
      .cpu_ac   (cpu_ac),
      .cpu_ma   (cpu_ma),
      .cpu_mb   (cpu_mb),
      .cpu_link (cpu_link),
      .dispout  (dispout),
      .linkout  (linkout)
   );

endmodule

// File: tb/tb_console_sequencer.sv
// tb/tb_console_sequencer.sv - bench for console_sequencer with a behavioural console model.
module tb_console_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] swreg;
   logic        run, loadpc, loadac, step, deposit;
   logic [1:0]  dispsel;
   logic [11:0] dispout;
   logic        linkout;
   logic [11:0] cpu_pc, cpu_ac, cpu_ma, cpu_mb;
   logic        cpu_link, cpu_done, cpu_halt;
   logic        cpu_go, pc_load, ac_load;
   logic [11:0] pc_data, ac_data;
   logic        mem_wr_req;
   logic [11:0] mem_addr, mem_wdata;
   logic        mem_wr_ack;
   logic        busy;

   console_sequencer dut (
      .clock(clock), .reset(reset), .swreg(swreg), .run(run),
      .loadpc(loadpc), .loadac(loadac), .step(step), .deposit(deposit),
      .dispsel(dispsel), .dispout(dispout), .linkout(linkout),
      .cpu_pc(cpu_pc), .cpu_ac(cpu_ac), .cpu_ma(cpu_ma), .cpu_mb(cpu_mb),
      .cpu_link(cpu_link), .cpu_done(cpu_done), .cpu_halt(cpu_halt),
      .cpu_go(cpu_go), .pc_load(pc_load), .ac_load(ac_load),
      .pc_data(pc_data), .ac_data(ac_data), .mem_wr_req(mem_wr_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_ack(mem_wr_ack),
      .busy(busy)
   );

   always #5 clock = ~clock;

`ifdef CONSOLE_DEP_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0o expected %0o at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: operating mode of the console plus what it has latched.
   localparam int M_IDLE = 10, M_RUN = 11, M_STOP = 12, M_HALT = 13;
   localparam int M_STEP = 14, M_DEPREQ = 15, M_DEPINC = 16;

   int          m_mode = M_IDLE;
   int          step_age = 0;
   logic [11:0] m_addr = '0, m_wdata = '0, m_disp = '0;
   logic        m_link = 1'b0;

   function automatic logic [11:0] pick(input logic [1:0] s);
      logic [11:0] taps [4];
      taps = '{cpu_pc, cpu_ac, cpu_ma, cpu_mb};
      return taps[s];
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_mode  <= M_IDLE;
         m_addr  <= '0;
         m_wdata <= '0;
         m_disp  <= '0;
         m_link  <= 1'b0;
      end else begin
         m_disp   <= pick(dispsel);
         m_link   <= cpu_link;
         step_age <= step_age + 1;
         if (m_mode == M_IDLE) begin
            if (run) m_mode <= M_RUN;
            else if (!loadpc && !loadac && deposit) begin
               m_mode  <= M_DEPREQ;
               m_addr  <= cpu_pc;
               m_wdata <= swreg;
            end else if (!loadpc && !loadac && step) begin
               m_mode   <= M_STEP;
               step_age <= 0;
            end
         end else if (m_mode == M_RUN) begin
            if (cpu_halt) m_mode <= M_HALT;
            else if (!run) m_mode <= M_STOP;
         end else if (m_mode == M_STOP) begin
            if (cpu_done) m_mode <= M_IDLE;
            else if (run) m_mode <= M_RUN;
         end else if (m_mode == M_HALT) begin
            if (!run) m_mode <= M_IDLE;
         end else if (m_mode == M_STEP) begin
            if (cpu_done || cpu_halt) m_mode <= M_IDLE;
         end else if (m_mode == M_DEPREQ) begin
            if (mem_wr_ack) m_mode <= AUTOINC ? M_DEPINC : M_IDLE;
         end else begin
            m_mode <= M_IDLE;
         end
      end
   end

   // Compare process: every cycle, once inputs for the cycle have settled.
   always @(negedge clock) begin
      if (check_en) begin
         logic        idle_ok, e_pcl, e_acl, inc;
         logic [11:0] e_pcd, e_acd;
         #2;
         idle_ok = !reset && m_mode == M_IDLE && !run;
         inc     = !reset && m_mode == M_DEPINC;
         e_pcl   = (idle_ok && loadpc) || inc;
         e_pcd   = (idle_ok && loadpc) ? swreg : inc ? 12'((int'(m_addr) + 1) % 4096) : 12'd0;
         e_acl   = idle_ok && !loadpc && loadac;
         e_acd   = e_acl ? swreg : 12'd0;
         chk("pc_load", pc_load, e_pcl);
         chk("pc_data", pc_data, e_pcd);
         chk("ac_load", ac_load, e_acl);
         chk("ac_data", ac_data, e_acd);
         chk("pc_ac_exclusive", pc_load && ac_load, 0);
         chk("cpu_go", cpu_go, (m_mode == M_RUN) || (m_mode == M_STEP && step_age == 0));
         chk("mem_wr_req", mem_wr_req, m_mode == M_DEPREQ);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
         chk("busy", busy, m_mode != M_IDLE);
         chk("dispout", dispout, m_disp);
         chk("linkout", linkout, m_link);
      end
   end

   task automatic quiet();
      loadpc = 0; loadac = 0; step = 0; deposit = 0;
      cpu_done = 0; cpu_halt = 0; mem_wr_ack = 0;
   endtask

   initial begin
      int nreq;
      reset = 1; swreg = 0; run = 0; dispsel = 0;
      cpu_pc = 0; cpu_ac = 0; cpu_ma = 0; cpu_mb = 0; cpu_link = 0;
      quiet();
      repeat (3) @(negedge clock);
      #3;
      chk("rst_cpu_go", cpu_go, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mem_wr_req", mem_wr_req, 0);
      chk("rst_dispout", dispout, 0);
      chk("rst_mem_addr", mem_addr, 0);
      @(negedge clock);
      reset = 0; check_en = 1;

      // loadpc while stopped
      @(negedge clock); swreg = 12'o0200; loadpc = 1;
      #3; chk("lpc_load", pc_load, 1); chk("lpc_data", pc_data, 12'o0200); chk("lpc_busy", busy, 0);
      @(negedge clock); quiet();
      #3; chk("lpc_busy_after", busy, 0);

      // priority: loadpc wins over loadac and step; display AC
      @(negedge clock); swreg = 12'o0055; loadpc = 1; loadac = 1; step = 1;
      dispsel = 2'b01; cpu_ac = 12'o4321;
      #3; chk("prio_pc_load", pc_load, 1); chk("prio_ac_load", ac_load, 0);
      @(negedge clock); quiet();
      #3; chk("prio_no_go", cpu_go, 0); chk("prio_busy", busy, 0); chk("disp_ac", dispout, 12'o4321);

      // single step
      @(negedge clock); step = 1;
      @(negedge clock); step = 0;
      #3; chk("step_go", cpu_go, 1); chk("step_busy", busy, 1);
      step = 1;
      @(negedge clock); step = 0; cpu_done = 1;
      #3; chk("step_go_once", cpu_go, 0);
      @(negedge clock); cpu_done = 0;
      #3; chk("step_done_busy", busy, 0); chk("step_retrig", cpu_go, 0);

      // run then halt
      @(negedge clock); run = 1;
      @(negedge clock);
      #3; chk("run_go", cpu_go, 1);
      cpu_halt = 1;
      @(negedge clock); cpu_halt = 0;
      #3; chk("halt_go", cpu_go, 0); chk("halt_busy", busy, 1);
      repeat (3) begin
         @(negedge clock);
         #3; chk("halt_hold_go", cpu_go, 0);
      end
      run = 0;
      @(negedge clock);
      #3; chk("halt_exit_busy", busy, 0);

      // deposit at 7777 with ack on the third request cycle
      @(negedge clock); cpu_pc = 12'o7777; swreg = 12'o1234; deposit = 1;
      #3; chk("dep_req_pre", mem_wr_req, 0);
      nreq = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); deposit = 0;
         if (i == 2) mem_wr_ack = 1;
         #3;
         if (mem_wr_req) nreq++;
         chk("dep_addr", mem_addr, 12'o7777);
         chk("dep_wdata", mem_wdata, 12'o1234);
      end
      @(negedge clock); mem_wr_ack = 0;
      #3; chk("dep_req_cycles", 12'(nreq), 3); chk("dep_req_drop", mem_wr_req, 0);
`ifdef CONSOLE_DEP_AUTOINC_EN
      chk("dep_inc_load", pc_load, 1); chk("dep_inc_data", pc_data, 12'o0000);
`else
      chk("dep_no_load", pc_load, 0); chk("dep_idle", busy, 0);
`endif
      @(negedge clock);
      #3; chk("dep_end_busy", busy, 0); chk("dep_end_load", pc_load, 0);

      // reset in the middle of a deposit
      @(negedge clock); deposit = 1;
      @(negedge clock); deposit = 0;
      #3; chk("rdep_req", mem_wr_req, 1);
      reset = 1;
      @(negedge clock); reset = 0;
      #3; chk("rdep_req_drop", mem_wr_req, 0); chk("rdep_busy", busy, 0); chk("rdep_no_load", pc_load, 0);

      // randomized traffic
      for (int n = 0; n < 4000; n++) begin
         @(negedge clock);
         reset    = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 19) == 0) run = ~run;
         loadpc   = ($urandom_range(0, 9) == 0);
         loadac   = ($urandom_range(0, 9) == 0);
         step     = ($urandom_range(0, 7) == 0);
         deposit  = ($urandom_range(0, 7) == 0);
         cpu_done = ($urandom_range(0, 3) == 0);
         cpu_halt = ($urandom_range(0, 29) == 0);
         mem_wr_ack = ($urandom_range(0, 2) == 0);
         swreg    = 12'($urandom);
         dispsel  = 2'($urandom);
         cpu_pc   = ($urandom_range(0, 7) == 0) ? 12'o7777 : 12'($urandom);
         cpu_ac   = 12'($urandom);
         cpu_ma   = 12'($urandom);
         cpu_mb   = 12'($urandom);
         cpu_link = 1'($urandom);
      end
      @(negedge clock);
      check_en = 0;
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
